// File: rtl/jt1943_prog_pkg.sv
// Shared types for the ROM-download SDRAM write buffer: FSM states, FIFO
// payload layout and the "no byte enabled" mask value.
package jt1943_prog_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } prog_state_e;

   localparam int PROG_DW   = 16;
   localparam int PROG_MW   = 2;
   localparam int PAYLOAD_W = PROG_DW + PROG_MW;

   localparam logic [PROG_MW-1:0] DQM_NONE = 2'b11;

   // A FIFO entry is {addr, payload}; the address width is set by the top.
   typedef struct packed {
      logic [PROG_DW-1:0] data16;
      logic [PROG_MW-1:0] dqm;
   } prog_payload_t;

   // Drops a new byte into the half of an existing entry that the new mask enables.
   function automatic prog_payload_t merge_byte(input prog_payload_t old,
                                                input logic [7:0]    b,
                                                input logic [1:0]    mask);
      prog_payload_t r;
      r = old;
      if (!mask[0]) r.data16[7:0]  = b;
      if (!mask[1]) r.data16[15:8] = b;
      r.dqm = old.dqm & mask;
      return r;
   endfunction

endpackage

// File: rtl/jt1943_prog_fifo.sv
// Small FIFO of pending SDRAM writes. The tail read/modify port only exists
// when JT1943_PROG_MERGE_EN is defined.
module jt1943_prog_fifo #(
   parameter int DEPTH = 4,
   parameter int EW    = 40
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [EW-1:0] din_i,
   output logic          full_o,
   output logic          empty_o,
   output logic [EW-1:0] head_o
`ifdef JT1943_PROG_MERGE_EN
   ,
   output logic [EW-1:0] tail_o,
   output logic          single_o,
   input  logic          tail_wr_i,
   input  logic [EW-1:0] tail_din_i
`endif
);
   localparam int IW = $clog2(DEPTH);
   localparam logic [IW:0] ONE = 1;

   logic [IW:0]   wr_q, rd_q;
   logic [EW-1:0] mem_q [DEPTH];
   logic          do_push, do_pop;

   // The extra pointer MSB tells a full FIFO apart from an empty one.
   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[IW] != rd_q[IW]) && (wr_q[IW-1:0] == rd_q[IW-1:0]);
   assign head_o  = mem_q[rd_q[IW-1:0]];
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || pop_i);

`ifdef JT1943_PROG_MERGE_EN
   logic [IW:0] tail_ptr;
   assign tail_ptr = wr_q - ONE;
   assign tail_o   = mem_q[tail_ptr[IW-1:0]];
   assign single_o = ((wr_q - rd_q) == ONE);

   always_ff @(posedge clk_i) begin
      if (do_push)        mem_q[wr_q[IW-1:0]]     <= din_i;
      else if (tail_wr_i) mem_q[tail_ptr[IW-1:0]] <= tail_din_i;
   end
`else
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q[IW-1:0]] <= din_i;
   end
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + ONE;
         if (do_pop)  rd_q <= rd_q + ONE;
      end
   end

endmodule

// File: rtl/jt1943_prog_sdram.sv
// Buffers the ROM-download byte stream and replays it as masked 16-bit SDRAM
// writes over req/ack/done. Define JT1943_PROG_MERGE_EN to pair bytes per word.
module jt1943_prog_sdram
   import jt1943_prog_pkg::*;
#(
   parameter int AW    = 22,
   parameter int DEPTH = 4
) (
   input  logic          clk_rom,
   input  logic          rst_n,
   input  logic          downloading,
   input  logic [AW-1:0] prog_addr,
   input  logic [7:0]    prog_data,
   input  logic [1:0]    prog_mask,
   input  logic          prog_we,
   output logic          sdram_req,
   output logic [AW-1:0] sdram_addr,
   output logic [15:0]   sdram_din,
   output logic [1:0]    sdram_dqm,
   input  logic          sdram_ack,
   input  logic          sdram_done,
   output logic          busy,
   output logic          overflow,
   output logic          prog_done
);
   localparam int EW = AW + PAYLOAD_W;

   prog_state_e   state_q, state_d;
   logic          req_q, req_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [15:0]   din_q, din_d;
   logic [1:0]    dqm_q, dqm_d;
   logic          busy_q, ovf_q, ovf_d, done_q, dl_q;
   logic          fifo_full, fifo_empty;
   logic          wr_valid, push, pop, drop, merge;
   logic [EW-1:0] new_entry, head, head_eff;

   assign wr_valid  = prog_we && (prog_mask != DQM_NONE);
   assign new_entry = {prog_addr, prog_data, prog_data, prog_mask};

`ifdef JT1943_PROG_MERGE_EN
   logic [EW-1:0] tail, merged;
   logic          single, tail_free;
   logic [AW-1:0] tail_addr;
   prog_payload_t tail_pl;

   assign tail_addr = tail[EW-1 -: AW];
   assign tail_pl   = prog_payload_t'(tail[PAYLOAD_W-1:0]);
   // A lone entry may still be merged while IDLE: the load below forwards the result.
   assign tail_free = !fifo_empty && (!single || state_q == ST_IDLE);
   assign merge     = wr_valid && tail_free && (tail_addr == prog_addr) &&
                      ((tail_pl.dqm | prog_mask) == DQM_NONE);
   assign merged    = {tail_addr, merge_byte(tail_pl, prog_data, prog_mask)};
   assign head_eff  = (merge && single) ? merged : head;
`else
   assign merge    = 1'b0;
   assign head_eff = head;
`endif

   assign push = wr_valid && !merge;
   assign drop = push && fifo_full && !pop;

   jt1943_prog_fifo #(
      .DEPTH (DEPTH),
      .EW    (EW)
   ) u_fifo (
      .clk_i      (clk_rom),
      .rst_ni     (rst_n),
      .push_i     (push),
      .pop_i      (pop),
      .din_i      (new_entry),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .head_o     (head)
`ifdef JT1943_PROG_MERGE_EN
      ,
      .tail_o     (tail),
      .single_o   (single),
      .tail_wr_i  (merge),
      .tail_din_i (merged)
`endif
   );

   always_comb begin
      state_d = state_q;
      req_d   = 1'b0;
      addr_d  = addr_q;
      din_d   = din_q;
      dqm_d   = dqm_q;
      pop     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               {addr_d, din_d, dqm_d} = head_eff;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            req_d = 1'b1;
            if (sdram_ack) begin
               req_d = 1'b0;
               if (sdram_done) begin
                  pop     = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (sdram_done) begin
               pop     = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A drop in the same cycle as a new download still marks the new session.
   assign ovf_d = ((downloading && !dl_q) ? 1'b0 : ovf_q) | drop;

   always_ff @(posedge clk_rom or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         req_q   <= 1'b0;
         addr_q  <= '0;
         din_q   <= '0;
         dqm_q   <= DQM_NONE;
         busy_q  <= 1'b0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
         dl_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         dqm_q   <= dqm_d;
         busy_q  <= !fifo_empty || (state_q != ST_IDLE);
         ovf_q   <= ovf_d;
         done_q  <= !downloading && fifo_empty && (state_q == ST_IDLE);
         dl_q    <= downloading;
      end
   end

   assign sdram_req  = req_q;
   assign sdram_addr = addr_q;
   assign sdram_din  = din_q;
   assign sdram_dqm  = dqm_q;
   assign busy       = busy_q;
   assign overflow   = ovf_q;
   assign prog_done  = done_q;

endmodule

// File: tb/tb_jt1943_prog_sdram.sv
// Bench for jt1943_prog_sdram: a scripted SDRAM controller pops expected writes
// from a scoreboard queue at each request. Honours JT1943_PROG_MERGE_EN.
`timescale 1ns/1ps
module tb_jt1943_prog_sdram;
   localparam int AW    = 22;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [15:0]   din;
      logic [1:0]    dqm;
   } exp_t;

   logic          clk_rom = 1'b0;
   logic          rst_n = 1'b0;
   logic          downloading = 1'b0;
   logic [AW-1:0] prog_addr = '0;
   logic [7:0]    prog_data = '0;
   logic [1:0]    prog_mask = 2'b11;
   logic          prog_we = 1'b0;
   logic          sdram_req;
   logic [AW-1:0] sdram_addr;
   logic [15:0]   sdram_din;
   logic [1:0]    sdram_dqm;
   logic          sdram_ack = 1'b0;
   logic          sdram_done = 1'b0;
   logic          busy, overflow, prog_done;

   jt1943_prog_sdram #(.AW(AW), .DEPTH(DEPTH)) dut (
      .clk_rom     (clk_rom),
      .rst_n       (rst_n),
      .downloading (downloading),
      .prog_addr   (prog_addr),
      .prog_data   (prog_data),
      .prog_mask   (prog_mask),
      .prog_we     (prog_we),
      .sdram_req   (sdram_req),
      .sdram_addr  (sdram_addr),
      .sdram_din   (sdram_din),
      .sdram_dqm   (sdram_dqm),
      .sdram_ack   (sdram_ack),
      .sdram_done  (sdram_done),
      .busy        (busy),
      .overflow    (overflow),
      .prog_done   (prog_done)
   );

   always #5 clk_rom = ~clk_rom;

   int cyc = 0;
   always @(posedge clk_rom) cyc <= cyc + 1;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t exp_q[$];
   int   n_exp_req = 0;

   // controller knobs and observations
   bit ctl_same = 1'b0;
   bit done_hold = 1'b0;
   bit ctl_active = 1'b0;
   int ack_dly = 3;
   int done_dly = 5;
   int req_cnt = 0;
   int last_req_cyc = 0;
   int last_done_cyc = -1000;
   int last_gap = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic exp_push(input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] m);
      exp_t x;
      x.addr = a;
      x.din  = d;
      x.dqm  = m;
      exp_q.push_back(x);
      n_exp_req++;
   endtask

   // Called at a negedge; the write is sampled at the next posedge.
   task automatic push_wr(input logic [AW-1:0] a, input logic [7:0] d, input logic [1:0] m,
                          input bit expect_it);
      prog_addr = a;
      prog_data = d;
      prog_mask = m;
      prog_we   = 1'b1;
      if (expect_it) exp_push(a, {d, d}, m);
      @(negedge clk_rom);
      prog_we = 1'b0;
   endtask

   task automatic wait_drain(input string tag, input int bound);
      int n;
      n = 0;
      while ((busy || ctl_active || sdram_req || exp_q.size() != 0) && n < bound) begin
         @(negedge clk_rom);
         n++;
      end
      chk({tag, "_timeout"}, (n >= bound), 1'b0);
      repeat (4) @(negedge clk_rom);
      chk({tag, "_req_count"}, req_cnt, n_exp_req);
   endtask

   // SDRAM controller model
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_rom);
         if (rst_n && sdram_req) begin
            ctl_active = 1'b1;
            req_cnt++;
            last_gap     = cyc - last_done_cyc;
            last_req_cyc = cyc;
            if (exp_q.size() == 0) begin
               chk("spurious_req", 1'b1, 1'b0);
               e.addr = sdram_addr;
               e.din  = sdram_din;
               e.dqm  = sdram_dqm;
            end else begin
               e = exp_q.pop_front();
               chk("req_addr", sdram_addr, e.addr);
               chk("req_din", sdram_din, e.din);
               chk("req_dqm", sdram_dqm, e.dqm);
            end
            repeat (ack_dly - 1) @(negedge clk_rom);
            chk("held_addr", sdram_addr, e.addr);
            chk("held_req", sdram_req, 1'b1);
            sdram_ack = 1'b1;
            if (ctl_same) sdram_done = 1'b1;
            @(negedge clk_rom);
            sdram_ack = 1'b0;
            chk("req_fall", sdram_req, 1'b0);
            if (ctl_same) begin
               sdram_done    = 1'b0;
               last_done_cyc = cyc;
            end else if (!done_hold) begin
               repeat (done_dly - 1) @(negedge clk_rom);
               sdram_done = 1'b1;
               @(negedge clk_rom);
               sdram_done    = 1'b0;
               last_done_cyc = cyc;
            end
            ctl_active = 1'b0;
         end
      end
   end

   initial begin
      int push_cyc;
      int n;
      int rc;

      repeat (3) @(negedge clk_rom);
      chk("rst_req", sdram_req, 1'b0);
      chk("rst_dqm", sdram_dqm, 2'b11);
      chk("rst_addr", sdram_addr, '0);
      chk("rst_din", sdram_din, '0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_overflow", overflow, 1'b0);
      chk("rst_prog_done", prog_done, 1'b0);
      downloading = 1'b1;
      rst_n = 1'b1;
      repeat (2) @(negedge clk_rom);

      // single write
      ack_dly  = 3;
      done_dly = 5;
      push_wr(22'h1234, 8'hA5, 2'b10, 1'b1);
      push_cyc = cyc;
      wait_drain("single", 200);
      chk("single_latency", last_req_cyc - push_cyc, 2);
      chk("single_busy", busy, 1'b0);
      chk("single_done_dl", prog_done, 1'b0);
      downloading = 1'b0;
      repeat (2) @(negedge clk_rom);
      chk("single_prog_done", prog_done, 1'b1);
      downloading = 1'b1;
      repeat (2) @(negedge clk_rom);
      chk("prog_done_dl_low", prog_done, 1'b0);

      // ack and done in the same cycle
      ctl_same = 1'b1;
      ack_dly  = 2;
      push_wr(22'h0100, 8'h11, 2'b10, 1'b1);
      push_wr(22'h0200, 8'h22, 2'b01, 1'b1);
      wait_drain("same", 200);
      chk("same_gap", last_gap, 2);
      ctl_same = 1'b0;

      // push and pop together while full
      ack_dly  = 2;
      done_dly = 8;
      for (int i = 0; i < 4; i++)
         push_wr(22'h0300 + 22'(i), 8'h30 + 8'(i), 2'b10, 1'b1);
      n = 0;
      while (!(ctl_active && cyc == last_req_cyc + ack_dly + done_dly - 1) && n < 100) begin
         @(negedge clk_rom);
         n++;
      end
      chk("full_sync_timeout", (n >= 100), 1'b0);
      push_wr(22'h0304, 8'h34, 2'b01, 1'b1);
      wait_drain("full_pushpop", 400);
      chk("full_pushpop_overflow", overflow, 1'b0);

      // burst of 6 while the controller stalls ack
      ack_dly  = 20;
      done_dly = 2;
`ifdef JT1943_PROG_MERGE_EN
      for (int k = 0; k < 3; k++)
         exp_push(22'h0400 + 22'(k), {8'h41 + 8'(2*k), 8'h40 + 8'(2*k)}, 2'b00);
`else
      exp_push(22'h0400, 16'h4040, 2'b10);
      exp_push(22'h0400, 16'h4141, 2'b01);
      exp_push(22'h0401, 16'h4242, 2'b10);
      exp_push(22'h0401, 16'h4343, 2'b01);
`endif
      for (int k = 0; k < 3; k++) begin
         push_wr(22'h0400 + 22'(k), 8'h40 + 8'(2*k), 2'b10, 1'b0);
         push_wr(22'h0400 + 22'(k), 8'h41 + 8'(2*k), 2'b01, 1'b0);
      end
      wait_drain("burst", 1000);
`ifdef JT1943_PROG_MERGE_EN
      chk("burst_overflow", overflow, 1'b0);
`else
      chk("burst_overflow", overflow, 1'b1);
`endif

      // rising edge of downloading clears overflow
      downloading = 1'b0;
      repeat (2) @(negedge clk_rom);
      downloading = 1'b1;
      repeat (2) @(negedge clk_rom);
      chk("overflow_clear", overflow, 1'b0);

      // all-masked write is ignored
      ack_dly  = 3;
      done_dly = 5;
      rc = req_cnt;
      push_wr(22'h0500, 8'h55, 2'b11, 1'b0);
      @(negedge clk_rom);
      chk("mask11_busy", busy, 1'b0);
      repeat (6) @(negedge clk_rom);
      chk("mask11_noreq", req_cnt, rc);

      // reset while waiting for done
      done_hold = 1'b1;
      ack_dly   = 2;
      rc = req_cnt;
      push_wr(22'h0600, 8'h66, 2'b10, 1'b1);
      n = 0;
      while (!(req_cnt == rc + 1 && !ctl_active) && n < 100) begin
         @(negedge clk_rom);
         n++;
      end
      chk("wait_ack_timeout", (n >= 100), 1'b0);
      repeat (2) @(negedge clk_rom);
      chk("wait_busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("midrst_req", sdram_req, 1'b0);
      chk("midrst_dqm", sdram_dqm, 2'b11);
      chk("midrst_busy", busy, 1'b0);
      @(negedge clk_rom);
      rst_n = 1'b1;
      done_hold = 1'b0;
      repeat (10) @(negedge clk_rom);
      chk("midrst_noreq", req_cnt, rc + 1);
      chk("midrst_busy_after", busy, 1'b0);

      // end of download
      downloading = 1'b0;
      repeat (2) @(negedge clk_rom);
      chk("final_prog_done", prog_done, 1'b1);
      chk("final_queue", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/jt1943_prog_sdram.md
# jt1943_prog_sdram

Write-side buffer between the download PROM/ROM steering stage and the SDRAM controller. It accepts the byte-wide programming stream (`prog_addr`/`prog_data`/`prog_mask`/`prog_we`) produced during ROM download. It queues the writes in a small FIFO and issues each one as a masked 16-bit SDRAM write using a req/ack/done handshake. Once download has ended and every queued write has retired, it reports completion.

## Interface
Parameters:
- `AW`, 22, word address width (matches `prog_addr`)
- `DEPTH`, 4, FIFO entries; power of two, minimum 2

Ports:
- `clk_rom`  in  1  ROM/SDRAM clock; sole clock
- `rst_n`  in  1  asynchronous active-low reset
- `downloading`  in  1  ROM download in progress
- `prog_addr`  in  AW  16-bit word address
- `prog_data`  in  8  byte to write
- `prog_mask`  in  2  active-low byte enables: 2'b10 = low byte, 2'b01 = high byte
- `prog_we`  in  1  one write per cycle high
- `sdram_req`  out  1  write request
- `sdram_addr`  out  AW  write address
- `sdram_din`  out  16  write data
- `sdram_dqm`  out  2  active-low byte mask
- `sdram_ack`  in  1  controller accepted the request
- `sdram_done`  in  1  write completed, one-cycle pulse
- `busy`  out  1  FIFO non-empty or FSM not IDLE
- `overflow`  out  1  sticky: a write was dropped
- `prog_done`  out  1  download finished and drained

Reset values:
- All outputs are 0, except `sdram_dqm` = 2'b11.
- The FIFO is empty and the FSM is in IDLE.

## Operation
Push path:
- Every cycle with `prog_we`=1 pushes one entry into the FIFO. An entry is {addr, data16, dqm}.
- data16 = {prog_data, prog_data}; dqm = `prog_mask`.
- Entries with `prog_mask` = 2'b11 are ignored and not pushed.

Issue FSM:
- IDLE: if the FIFO is non-empty, load the head entry into the output registers and go to REQ.
- REQ: `sdram_req`=1. The address, data and mask outputs are held stable. On `sdram_ack` go to WAIT.
- WAIT: `sdram_req`=0. On `sdram_done`, pop the head and go to IDLE.
- `sdram_done` arriving in REQ together with `sdram_ack` is treated as ack followed by done: the entry pops and the FSM goes straight to IDLE.
- A `sdram_done` arriving in IDLE is ignored.

FIFO boundaries:
- Full, with a push and no pop in the same cycle: the write is dropped and `overflow` is set.
- Full, with a push and a pop in the same cycle: the push is accepted.
- Empty: IDLE stays idle, with no spurious request.
- Read and write pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH. Full and empty are decided by the MSB comparison.

`overflow`:
- Cleared by reset.
- Cleared on the rising edge of `downloading`.
- Otherwise sticky.

`prog_done`:
- Equals !downloading && FIFO empty && FSM in IDLE, registered.
- Low during download.

Reset mid-transaction:
- Everything returns to reset values immediately.
- The in-flight SDRAM write is abandoned; the controller owns recovery.

## Timing
- Push at edge N: the entry is visible at edge N+1.
- If the FSM is IDLE, `sdram_req` rises after edge N+2. Minimum push-to-req latency is 2 cycles.
- `sdram_req` falls on the edge after `sdram_ack` is sampled high.
- Pop happens on the edge that samples `sdram_done`. The FSM is back in IDLE the next cycle, so the next `sdram_req` rises no earlier than 2 cycles after `sdram_done`.
- Throughput is bounded by controller latency plus 2 cycles per write.
- `busy` and `prog_done` are registered and lag the FIFO/FSM state by one cycle.

## Configuration
Macro: `JT1943_PROG_MERGE_EN`.
- Defined — merge rule: an incoming write is merged into the youngest FIFO entry when all of the following hold:
  - the youngest entry is not the head currently latched by the FSM;
  - its address equals `prog_addr`;
  - the two masks do not overlap.
- Defined — merge effect:
  - the new byte is written into the selected half of data16;
  - dqm becomes old dqm & new mask;
  - no new entry is allocated, and a merge is never counted as an overflow.
- Undefined: every byte is a separate masked write. There is no address comparator.

## Structure
- Package `jt1943_prog_pkg` holds:
  - the FSM state enum (IDLE, REQ, WAIT);
  - the FIFO entry struct/width constants (addr, data16, dqm);
  - the default mask 2'b11.
- Sub-module `jt1943_prog_fifo`:
  - parameterised on `DEPTH`;
  - ports: push/pop, full/empty, head output, tail-entry read/modify port (used only under the macro).
- The top level holds the FSM, output registers, the overflow/done logic and the merge decision.

## Test plan
- Single write: prog_addr=22'h1234, data=8'hA5, mask=2'b10.
  - `sdram_req` rises 2 cycles later with addr=22'h1234, din=16'hA5A5, dqm=2'b10.
  - ack after 3 cycles, done after 5; `busy` drops, and `prog_done` rises after `downloading` falls.
- Burst of 6 back-to-back writes with DEPTH=4 and the controller stalling ack for 20 cycles.
  - Without the macro: 4 writes retire in order and `overflow`=1.
  - With the macro and paired low/high bytes at 3 addresses: 3 merged writes with dqm=2'b00, and `overflow`=0.
- Push and pop in the same cycle while full: no drop, `overflow` stays 0, order is preserved.
- `sdram_ack` and `sdram_done` high in the same cycle: the entry pops, the FSM goes to IDLE, and the next req follows 2 cycles later.
- `rst_n` low during WAIT: `sdram_req`=0, dqm=2'b11, `busy`=0 asynchronously. No req is issued after release until a new `prog_we`.
- Rising edge of `downloading` with `overflow`=1: `overflow` clears. A mask of 2'b11 with `prog_we`=1 causes no push and no req.
